reg_file_sb: RTL

- Parametrised successor to the LC-3 register file: DEPTH x WIDTH general-purpose registers with two asynchronous read ports and one write port.
- Optional write-to-read bypass.
- Per-register busy scoreboard, so the control FSM can stall on registers that a multi-cycle producer (e.g. an LDR in flight) has yet to write.
- Registered NZP condition codes derived from the written value.
- Sits between the bus/ALU and the SR1/SR2 operand paths.

---
 rtl/reg_file_sb.sv | 103 ++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// Parametrised register file with two async read ports, one write port,
// optional write-to-read bypass, per-register busy scoreboard and NZP codes.
`timescale 1ns/1ps

module reg_file_sb #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned AW     = $clog2(DEPTH),
    parameter int unsigned BYPASS = 1
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_cc,
    input  logic             claim_en,
    input  logic [AW-1:0]    claim_addr,
    input  logic [AW-1:0]    rd_addr0,
    input  logic [AW-1:0]    rd_addr1,
    output logic [WIDTH-1:0] rd_data0,
    output logic [WIDTH-1:0] rd_data1,
    output logic             rd_busy0,
    output logic             rd_busy1,
    output logic             N_out,
    output logic             Z_out,
    output logic             P_out,
    output logic             claim_conflict,
    output logic [DEPTH-1:0] busy_vec
);

    localparam bit BYP = (BYPASS != 0);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [2:0]       nzp_q;
    logic [2:0]       nzp_d;
    logic             conflict_q;
    logic             conflict_d;

    logic             byp0_c;
    logic             byp1_c;
    logic             wr_neg_c;
    logic             wr_zero_c;

    assign wr_neg_c  = wr_data[WIDTH-1];
    assign wr_zero_c = (wr_data == '0);

    // Next-state: write, scoreboard update (claim beats retire), CC load, conflict detect
    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        nzp_d      = nzp_q;
        conflict_d = 1'b0;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
            if (wr_cc) begin
                nzp_d = {wr_neg_c, wr_zero_c, ~wr_neg_c & ~wr_zero_c};
            end
        end
        if (claim_en) begin
            conflict_d         = busy_q[claim_addr] & ~(wr_en & (wr_addr == claim_addr));
            busy_d[claim_addr] = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            nzp_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            nzp_q      <= nzp_d;
            conflict_q <= conflict_d;
        end
    end

    // Read ports: forward same-cycle write data and clear busy for a retiring write
    assign byp0_c = BYP & wr_en & (wr_addr == rd_addr0);
    assign byp1_c = BYP & wr_en & (wr_addr == rd_addr1);

    assign rd_data0 = byp0_c ? wr_data : regs_q[rd_addr0];
    assign rd_data1 = byp1_c ? wr_data : regs_q[rd_addr1];

    assign rd_busy0 = busy_q[rd_addr0] & ~(byp0_c & ~(claim_en & (claim_addr == rd_addr0)));
    assign rd_busy1 = busy_q[rd_addr1] & ~(byp1_c & ~(claim_en & (claim_addr == rd_addr1)));

    assign N_out          = nzp_q[2];
    assign Z_out          = nzp_q[1];
    assign P_out          = nzp_q[0];
    assign claim_conflict = conflict_q;
    assign busy_vec       = busy_q;

endmodule
